// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial pattern detector with saturating hit counter
//
// Purpose:
//   Watches a single-bit serial stream (MSB of the pattern first) and raises a
//   registered Moore flag for one cycle each time the last PAT_W qualified bits
//   equal the programmed pattern. Detection can be overlapping or
//   non-overlapping, selected per cycle. A saturating counter tallies hits.
//
// Optional feature (macro SEQ_DET_MASK_EN):
//   Adds input pat_mask, captured on cfg_load. Bits with mask 0 are don't-care
//   in the compare. Without the macro the port is absent and every bit counts.
//
// Parameters:
//   PAT_W    pattern length in bits (2..32)
//   CNT_W    hit counter width
//   RST_PAT  pattern held after reset
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   x         in   serial data bit
//   x_valid   in   x is sampled only when 1
//   overlap   in   1 = overlapping detection, 0 = non-overlapping
//   pat       in   new pattern, captured on cfg_load
//   pat_mask  in   compare mask, captured on cfg_load (SEQ_DET_MASK_EN only)
//   cfg_load  in   load pattern and flush history
//   clear     in   flush history, flag and counter
//   y         out  registered match flag, one cycle per hit
//   hit_cnt   out  saturating hit count
//   armed     out  history holds PAT_W valid bits

module seq_detect_param #(
    parameter int                    PAT_W   = 4,
    parameter int                    CNT_W   = 8,
    parameter logic [PAT_W-1:0]      RST_PAT = PAT_W'(4'b1011)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pat,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] pat_mask,
`endif
    input  logic             cfg_load,
    input  logic             clear,
    output logic             y,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             armed
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // The fill counter is the real state; the enum mirrors it so armed comes
    // straight from a flop rather than a compare on fill_q.
    typedef enum logic {
        S_FILLING = 1'b0,
        S_ARMED   = 1'b1
    } state_t;

    logic [PAT_W-1:0]  hist_q;
    logic [FILL_W-1:0] fill_q;
    state_t            state_q;
    logic              y_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PAT_W-1:0]  pat_q;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]  mask_q;
`endif

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_inc;
    logic [FILL_W-1:0] fill_n;
    logic              bits_eq;
    logic              match;
    logic              cnt_sat;

    always_comb begin
        hist_n   = {hist_q[PAT_W-2:0], x};
        fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
`ifdef SEQ_DET_MASK_EN
        bits_eq  = (((hist_n ^ pat_q) & mask_q) == '0);
`else
        bits_eq  = (hist_n == pat_q);
`endif
        // Requiring a full history stops an all-zero pattern from matching the
        // zeros left in hist after reset/flush.
        match    = (fill_inc == FILL_FULL) && bits_eq;
        // Non-overlap restarts filling after a hit so the next hit needs
        // PAT_W fresh bits; overlap keeps the window full.
        fill_n   = (match && !overlap) ? '0 : fill_inc;
        cnt_sat  = &cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= S_FILLING;
            y_q     <= 1'b0;
            cnt_q   <= '0;
            pat_q   <= RST_PAT;
`ifdef SEQ_DET_MASK_EN
            mask_q  <= '1;
`endif
        end else if (clear) begin
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= S_FILLING;
            y_q     <= 1'b0;
            cnt_q   <= '0;
        end else if (cfg_load) begin
            pat_q   <= pat;
`ifdef SEQ_DET_MASK_EN
            mask_q  <= pat_mask;
`endif
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= S_FILLING;
            y_q     <= 1'b0;
        end else if (x_valid) begin
            hist_q  <= hist_n;
            fill_q  <= fill_n;
            state_q <= (fill_n == FILL_FULL) ? S_ARMED : S_FILLING;
            y_q     <= match;
            if (match && !cnt_sat) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            // Idle cycles keep the partial match; only the pulse drops.
            y_q <= 1'b0;
        end
    end

    assign y       = y_q;
    assign hit_cnt = cnt_q;
    assign armed   = (state_q == S_ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - self-checking bench for seq_detect_param

module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       x;
    logic       x_valid;
    logic       overlap;
    logic [3:0] pat;
    logic [3:0] pat_mask;
    logic       cfg_load;
    logic       clear;

    logic       y_a, armed_a;
    logic [7:0] cnt_a;
    logic       y_b, armed_b;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat(pat),
`ifdef SEQ_DET_MASK_EN
        .pat_mask(pat_mask),
`endif
        .cfg_load(cfg_load), .clear(clear),
        .y(y_a), .hit_cnt(cnt_a), .armed(armed_a)
    );

    seq_detect_param #(.PAT_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat(pat),
`ifdef SEQ_DET_MASK_EN
        .pat_mask(pat_mask),
`endif
        .cfg_load(cfg_load), .clear(clear),
        .y(y_b), .hit_cnt(cnt_b), .armed(armed_b)
    );

    // One clock of stimulus: the expected y is queued as the inputs are
    // driven and popped/compared once the DUT has registered them.
    task automatic cycle(input logic xb, input logic v, input logic cl,
                         input logic ld, input logic ey, input string tag);
        logic e;
        x        = xb;
        x_valid  = v;
        clear    = cl;
        cfg_load = ld;
        exp_q.push_back(ey);
        @(posedge clk);
        #1;
        x_valid  = 1'b0;
        clear    = 1'b0;
        cfg_load = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (y_a !== e) begin
            errors++;
            $display("FAIL %s y_a got %b exp %b", tag, y_a, e);
        end
        checks++;
        if (y_b !== e) begin
            errors++;
            $display("FAIL %s y_b got %b exp %b", tag, y_b, e);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; x = 1'b0; x_valid = 1'b0; overlap = 1'b1;
        pat = 4'b0000; pat_mask = 4'b1111; cfg_load = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (y_a !== 1'b0 || cnt_a !== 8'd0 || armed_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a y=%b cnt=%0d armed=%b exp 0/0/0", y_a, cnt_a, armed_a);
        end
        checks++;
        if (y_b !== 1'b0 || cnt_b !== 2'd0 || armed_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b y=%b cnt=%0d armed=%b exp 0/0/0", y_b, cnt_b, armed_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_overlap;
        logic [6:0] bits = 7'b1011011;
        logic [6:0] ys   = 7'b0001001;
        overlap = 1'b1;
        for (int i = 6; i >= 0; i--) cycle(bits[i], 1'b1, 1'b0, 1'b0, ys[i], "overlap");
        checks++;
        if (cnt_a !== 8'd2 || cnt_b !== 2'd2) begin
            errors++;
            $display("FAIL overlap_cnt got %0d/%0d exp 2/2", cnt_a, cnt_b);
        end
        checks++;
        if (armed_a !== 1'b1) begin
            errors++;
            $display("FAIL overlap_armed got %b exp 1", armed_a);
        end
    endtask

    task automatic test_non_overlap;
        logic [10:0] bits = 11'b1011011_1011;
        logic [10:0] ys   = 11'b0001000_0001;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "nonov_clear");
        overlap = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            cycle(bits[i], 1'b1, 1'b0, 1'b0, ys[i], "nonov");
            if (i == 7) begin
                checks++;
                if (cnt_a !== 8'd1 || armed_a !== 1'b0) begin
                    errors++;
                    $display("FAIL nonov_first cnt=%0d armed=%b exp 1/0", cnt_a, armed_a);
                end
            end
        end
        checks++;
        if (cnt_a !== 8'd2) begin
            errors++;
            $display("FAIL nonov_cnt got %0d exp 2", cnt_a);
        end
    endtask

    task automatic test_gap;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "gap_clear");
        overlap = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap_b1");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap_b2");
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gap_idle");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap_b3");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "gap_b4");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap_after");
        checks++;
        if (cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL gap_cnt got %0d exp 1", cnt_a);
        end
    endtask

    task automatic test_zero_pattern;
        logic [4:0] ys_non = 5'b10001;
        pat = 4'b0000;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "zero_load");
        checks++;
        if (cnt_a !== 8'd1 || armed_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_load cnt=%0d armed=%b exp 1/0", cnt_a, armed_a);
        end
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b1, 1'b0, 1'b0, (i >= 3), "zero_ov");
        checks++;
        if (cnt_a !== 8'd6 || cnt_b !== 2'd3) begin
            errors++;
            $display("FAIL zero_ov_cnt got %0d/%0d exp 6/3", cnt_a, cnt_b);
        end
        overlap = 1'b0;
        for (int i = 4; i >= 0; i--)
            cycle(1'b0, 1'b1, 1'b0, 1'b0, ys_non[i], "zero_nonov");
        checks++;
        if (cnt_a !== 8'd8) begin
            errors++;
            $display("FAIL zero_nonov_cnt got %0d exp 8", cnt_a);
        end
        pat = 4'b1011;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "zero_restore");
    endtask

    task automatic test_saturation;
        logic [15:0] bits = 16'b1011011011011011;
        logic [15:0] ys   = 16'b0001001001001001;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "sat_clear");
        overlap = 1'b1;
        for (int i = 15; i >= 0; i--) cycle(bits[i], 1'b1, 1'b0, 1'b0, ys[i], "sat");
        checks++;
        if (cnt_a !== 8'd5 || cnt_b !== 2'd3 || armed_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_cnt got %0d/%0d armed %b exp 5/3/1", cnt_a, cnt_b, armed_b);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "sat_clear2");
        checks++;
        if (cnt_a !== 8'd0 || cnt_b !== 2'd0 || armed_a !== 1'b0 || armed_b !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear cnt=%0d/%0d armed=%b/%b exp 0/0/0/0",
                     cnt_a, cnt_b, armed_a, armed_b);
        end
    endtask

    task automatic test_async_reset;
        logic [6:0] bits = 7'b1011101;
        logic [6:0] ys   = 7'b0001000;
        overlap = 1'b1;
        for (int i = 6; i >= 0; i--) cycle(bits[i], 1'b1, 1'b0, 1'b0, ys[i], "arst");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y_a !== 1'b0 || cnt_a !== 8'd0 || cnt_b !== 2'd0 || armed_a !== 1'b0) begin
            errors++;
            $display("FAIL arst_async y=%b cnt=%0d/%0d armed=%b exp 0/0/0/0",
                     y_a, cnt_a, cnt_b, armed_a);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "arst_after");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "arst_idle");
        checks++;
        if (cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL arst_cnt got %0d exp 0", cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gap();
        test_zero_pattern();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
